aes_round_ctrl: RTL and testbench
=================================

Name: aes_round_ctrl

Overview:
- Round sequencer for the iterative AES datapath (state register, round function, on-the-fly key expansion) inside the aes core.
- Accepts a start request once plaintext/key have been shifted in over SPI.
- Drives per-cycle load, round-select, key-step and last-round controls for encrypt or decrypt, then pulses done.
- The SPI shift logic reads the result when done is asserted.

Parameters:
K, 128, key length in bits; legal values 128/192/256 give Nr = 10/12/14; any other value is an elaboration error.
INV, 2, direction mode: 0 = encrypt only, 1 = decrypt only, 2 = direction selected per operation by the dir input.

Ports:
clk  in  1  system clock, rising-edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  request to begin an operation; sampled only in IDLE.
dir  in  1  0 = encrypt, 1 = decrypt; used only when INV==2, latched with start.
ld_state  out  1  load input block into datapath state register.
ld_key  out  1  load cipher key into key-expansion register.
add_key_only  out  1  initial AddRoundKey cycle; no SubBytes/ShiftRows/MixColumns.
round_en  out  1  full or final round executes this cycle.
last_round  out  1  final round; MixColumns (InvMixColumns) skipped.
key_step  out  1  advance key-expansion register by one round key at the end of this cycle.
key_dir  out  1  0 = forward expansion, 1 = reverse expansion.
dec  out  1  latched direction, held stable from LOAD through DONE.
round  out  4  index of the round key applied this cycle.
busy  out  1  operation in progress.
done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, any time, including mid-operation):
  - State goes to IDLE; latched direction clears to 0.
  - All outputs are 0, including round = 0.
  - The operation in flight is abandoned; no done pulse is produced.
- Outputs are decoded only from registered state, counter and latched direction. There is no combinational path from an input to an output.
- FSM states: IDLE, LOAD, EXPAND, ADDK, ROUND, FINAL, DONE.
- IDLE:
  - busy = 0.
  - On a clk edge with start = 1, latch direction: INV==0 gives 0, INV==1 gives 1, INV==2 gives dir. Then go to LOAD.
- LOAD, 1 cycle:
  - ld_state = 1, ld_key = 1, round = 0.
  - Next state: EXPAND if decrypting, else ADDK.
- EXPAND, decrypt only, exactly Nr cycles:
  - key_step = 1, key_dir = 0, round = 0.
  - An internal counter runs 1..Nr; when it reaches Nr, go to ADDK.
- ADDK, 1 cycle:
  - add_key_only = 1, key_step = 1.
  - Encrypt: round = 0, key_dir = 0.
  - Decrypt: round = Nr, key_dir = 1.
- ROUND, Nr-1 cycles:
  - round_en = 1, key_step = 1.
  - Encrypt: round counts 1 up to Nr-1.
  - Decrypt: round counts Nr-1 down to 1, with key_dir = 1.
  - Go to FINAL after the last count.
- FINAL, 1 cycle:
  - round_en = 1, last_round = 1, key_step = 0.
  - round = Nr (encrypt) or 0 (decrypt).
- DONE, 1 cycle:
  - done = 1, busy = 0.
  - Always returns to IDLE; start is ignored here.
- busy = 1 in LOAD, EXPAND, ADDK, ROUND and FINAL.
- dec is held at the latched direction in every non-IDLE state and is 0 in IDLE.
- key_dir is 0 whenever key_step = 0.
- Latency, with edge 0 being the one that samples start:
  - Encrypt: done is high in cycle Nr+3 after edge 0.
  - Decrypt: done is high in cycle 2Nr+3 after edge 0.
- Throughput:
  - start held high continuously restarts from IDLE one cycle after DONE.
  - Back-to-back period is Nr+4 cycles (encrypt) or 2Nr+4 cycles (decrypt).
- start or dir changes while not in IDLE are ignored; the latched direction is not disturbed.
- round never wraps:
  - Encrypt stays within 0..Nr.
  - Decrypt ROUND stops at 1, then FINAL forces 0.

Test Plan:
- K=128, INV=0, one start pulse:
  - LOAD, then ADDK at round 0, then round_en with round 1..9, then FINAL with round 10 and last_round = 1.
  - done high exactly 13 cycles after the start edge; busy high for 12 cycles.
- K=192, INV=2, dir=0:
  - round sequence 0..12.
  - last_round only at round 12; done at cycle 15; key_dir never 1.
- K=256, INV=2, dir=1:
  - 14 EXPAND cycles with key_step = 1 and key_dir = 0.
  - ADDK at round 14, then ROUND 13 down to 1, then FINAL at round 0.
  - done at cycle 31; dec = 1 throughout.
- K=128, INV=1, dir=0:
  - decrypt is forced; done at cycle 23; dec = 1.
- Start handling, K=128 encrypt:
  - Pulse start and toggle dir at cycle 5: no effect on the sequence.
  - start held high: second LOAD begins 14 cycles after the first; done pulses are 14 cycles apart.
- Reset mid-operation:
  - Assert reset asynchronously during ROUND at round 4: all outputs go to 0 immediately and the FSM is in IDLE.
  - No done pulse appears afterwards.
  - A new start after reset release completes with nominal latency.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the iterative AES datapath: load, optional key pre-expansion, AddRoundKey, rounds, done.
// Latency: done in cycle Nr+3 (encrypt) or 2Nr+3 (decrypt) after the edge that samples start.
// Backpressure: none; start is sampled only in IDLE, and start/dir are ignored while an operation runs.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   start, dir        operation request and direction (dir used only when INV==2)
//   ld_state, ld_key  load block / cipher key into the datapath
//   add_key_only      initial AddRoundKey-only cycle
//   round_en          full or final round executes this cycle
//   last_round        final round (no (Inv)MixColumns)
//   key_step, key_dir advance key register at end of cycle; 0 = forward, 1 = reverse
//   dec               latched direction (0 in IDLE)
//   round             index of round key applied this cycle
//   busy, done        operation in progress / one-cycle completion pulse
module aes_round_ctrl #(
    parameter int K   = 128,
    parameter int INV = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       dir,
    output logic       ld_state,
    output logic       ld_key,
    output logic       add_key_only,
    output logic       round_en,
    output logic       last_round,
    output logic       key_step,
    output logic       key_dir,
    output logic       dec,
    output logic [3:0] round,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] NR = (K == 256) ? 4'd14 :
                                (K == 192) ? 4'd12 : 4'd10;

    generate
        if (!(K == 128 || K == 192 || K == 256)) begin : g_bad_k
            $error("aes_round_ctrl: K must be 128, 192 or 256");
        end
        if (!(INV == 0 || INV == 1 || INV == 2)) begin : g_bad_inv
            $error("aes_round_ctrl: INV must be 0, 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXPAND,
        S_ADDK,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       dec_q, dec_d;
    logic       start_dir;

    // Direction the next operation will run in; fixed by INV unless per-op selectable.
    always_comb begin
        start_dir = 1'b0;
        if (INV == 1)      start_dir = 1'b1;
        else if (INV == 2) start_dir = dir;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
        end
    end

    // Next-state logic plus output decode. Outputs depend only on state_q,
    // cnt_q and dec_q, so there is no input-to-output combinational path.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dec_d        = dec_q;
        ld_state     = 1'b0;
        ld_key       = 1'b0;
        add_key_only = 1'b0;
        round_en     = 1'b0;
        last_round   = 1'b0;
        key_step     = 1'b0;
        key_dir      = 1'b0;
        dec          = 1'b0;
        round        = 4'd0;
        busy         = 1'b0;
        done         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dec_d   = start_dir;
                    cnt_d   = 4'd1;
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                ld_state = 1'b1;
                ld_key   = 1'b1;
                busy     = 1'b1;
                dec      = dec_q;
                cnt_d    = 4'd1;
                state_d  = dec_q ? S_EXPAND : S_ADDK;
            end

            // Decrypt only: walk the key schedule forward to the last round key
            // so the rounds can then consume keys in reverse order.
            S_EXPAND: begin
                key_step = 1'b1;
                busy     = 1'b1;
                dec      = dec_q;
                if (cnt_q == NR) begin
                    state_d = S_ADDK;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            S_ADDK: begin
                add_key_only = 1'b1;
                key_step     = 1'b1;
                key_dir      = dec_q;
                busy         = 1'b1;
                dec          = dec_q;
                round        = dec_q ? NR : 4'd0;
                cnt_d        = dec_q ? (NR - 4'd1) : 4'd1;
                state_d      = S_ROUND;
            end

            // Counter doubles as the round index; it stops at Nr-1 (encrypt)
            // or 1 (decrypt) so it never wraps.
            S_ROUND: begin
                round_en = 1'b1;
                key_step = 1'b1;
                key_dir  = dec_q;
                busy     = 1'b1;
                dec      = dec_q;
                round    = cnt_q;
                if (dec_q ? (cnt_q == 4'd1) : (cnt_q == NR - 4'd1)) begin
                    state_d = S_FINAL;
                end else begin
                    cnt_d = dec_q ? (cnt_q - 4'd1) : (cnt_q + 4'd1);
                end
            end

            S_FINAL: begin
                round_en   = 1'b1;
                last_round = 1'b1;
                busy       = 1'b1;
                dec        = dec_q;
                round      = dec_q ? 4'd0 : NR;
                cnt_d      = 4'd0;
                state_d    = S_DONE;
            end

            S_DONE: begin
                done    = 1'b1;
                dec     = dec_q;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
module tb_aes_round_ctrl;

    localparam int NI = 5;
    // Instance table: 0 K128 enc-only, 1 K192 sel, 2 K256 sel, 3 K128 dec-only, 4 K128 sel
    localparam int KS   [NI] = '{128, 192, 256, 128, 128};
    localparam int INVS [NI] = '{0,   2,   2,   1,   2};

    typedef struct packed {
        logic       ld_state;
        logic       ld_key;
        logic       add_key_only;
        logic       round_en;
        logic       last_round;
        logic       key_step;
        logic       key_dir;
        logic       dec;
        logic       busy;
        logic       done;
        logic [3:0] round;
    } out_t;

    logic          clk;
    logic          reset;
    logic [NI-1:0] st;
    logic [NI-1:0] dr;

    wire [NI-1:0]   ld_state_w, ld_key_w, add_key_only_w, round_en_w, last_round_w;
    wire [NI-1:0]   key_step_w, key_dir_w, dec_w, busy_w, done_w;
    wire [NI*4-1:0] round_w;

    int tests = 0;
    int fails = 0;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        aes_round_ctrl #(.K(KS[gi]), .INV(INVS[gi])) u_dut (
            .clk          (clk),
            .reset        (reset),
            .start        (st[gi]),
            .dir          (dr[gi]),
            .ld_state     (ld_state_w[gi]),
            .ld_key       (ld_key_w[gi]),
            .add_key_only (add_key_only_w[gi]),
            .round_en     (round_en_w[gi]),
            .last_round   (last_round_w[gi]),
            .key_step     (key_step_w[gi]),
            .key_dir      (key_dir_w[gi]),
            .dec          (dec_w[gi]),
            .round        (round_w[gi*4 +: 4]),
            .busy         (busy_w[gi]),
            .done         (done_w[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t obs(input int i);
        out_t o;
        o.ld_state     = ld_state_w[i];
        o.ld_key       = ld_key_w[i];
        o.add_key_only = add_key_only_w[i];
        o.round_en     = round_en_w[i];
        o.last_round   = last_round_w[i];
        o.key_step     = key_step_w[i];
        o.key_dir      = key_dir_w[i];
        o.dec          = dec_w[i];
        o.busy         = busy_w[i];
        o.done         = done_w[i];
        o.round        = round_w[i*4 +: 4];
        return o;
    endfunction

    // Expected outputs in cycle c after the start-sampling edge (cycle-indexed timeline).
    function automatic out_t exp_at(input int c, input int nr, input bit d);
        out_t e = '0;
        if (!d) begin
            if (c == 1) begin
                e.ld_state = 1; e.ld_key = 1; e.busy = 1;
            end else if (c == 2) begin
                e.add_key_only = 1; e.key_step = 1; e.busy = 1;
            end else if (c >= 3 && c <= nr + 1) begin
                e.round_en = 1; e.key_step = 1; e.busy = 1; e.round = 4'(c - 2);
            end else if (c == nr + 2) begin
                e.round_en = 1; e.last_round = 1; e.busy = 1; e.round = 4'(nr);
            end else if (c == nr + 3) begin
                e.done = 1;
            end
        end else begin
            if (c == 1) begin
                e.ld_state = 1; e.ld_key = 1; e.busy = 1; e.dec = 1;
            end else if (c >= 2 && c <= nr + 1) begin
                e.key_step = 1; e.busy = 1; e.dec = 1;
            end else if (c == nr + 2) begin
                e.add_key_only = 1; e.key_step = 1; e.key_dir = 1; e.busy = 1; e.dec = 1;
                e.round = 4'(nr);
            end else if (c >= nr + 3 && c <= 2 * nr + 1) begin
                e.round_en = 1; e.key_step = 1; e.key_dir = 1; e.busy = 1; e.dec = 1;
                e.round = 4'(2 * nr + 2 - c);
            end else if (c == 2 * nr + 2) begin
                e.round_en = 1; e.last_round = 1; e.busy = 1; e.dec = 1;
            end else if (c == 2 * nr + 3) begin
                e.done = 1; e.dec = 1;
            end
        end
        return e;
    endfunction

    task automatic chk(input string tag, input out_t o, input out_t e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One start pulse on instance i, then check every cycle through two idle cycles.
    task automatic run_op(input string name, input int i, input int nr, input bit d, input bit dir_v);
        int last;
        last = d ? 2 * nr + 5 : nr + 5;
        st[i] = 1'b1;
        dr[i] = dir_v;
        tick();
        st[i] = 1'b0;
        for (int c = 1; c <= last; c++) begin
            chk($sformatf("%s_c%0d", name, c), obs(i), exp_at(c, nr, d));
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        st    = '0;
        dr    = '0;
        #3;
        for (int i = 0; i < NI; i++) chk($sformatf("reset_u%0d", i), obs(i), '0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        run_op("enc128", 0, 10, 1'b0, 1'b0);
        run_op("enc192", 1, 12, 1'b0, 1'b0);
        run_op("dec256", 2, 14, 1'b1, 1'b1);
        run_op("dec128_forced", 3, 10, 1'b1, 1'b0);

        // start and dir disturbed mid-operation: sequence must be unaffected
        st[4] = 1'b1;
        dr[4] = 1'b0;
        tick();
        st[4] = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            chk($sformatf("ignore_c%0d", c), obs(4), exp_at(c, 10, 1'b0));
            if (c == 5) begin
                st[4] = 1'b1; dr[4] = 1'b1;
            end else begin
                st[4] = 1'b0; dr[4] = 1'b0;
            end
            tick();
        end

        // start held high: second operation 14 cycles after the first
        st[4] = 1'b1;
        dr[4] = 1'b0;
        tick();
        for (int c = 1; c <= 28; c++) begin
            chk($sformatf("held_c%0d", c), obs(4), exp_at((c > 14) ? c - 14 : c, 10, 1'b0));
            if (c == 15) st[4] = 1'b0;
            tick();
        end

        // asynchronous reset during ROUND at round 4
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("prerst_c%0d", c), obs(0), exp_at(c, 10, 1'b0));
            if (c < 6) tick();
        end
        #2;
        reset = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) chk($sformatf("midrst_u%0d", i), obs(i), '0);
        tick();
        tick();
        reset = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            chk($sformatf("postrst_idle_c%0d", c), obs(0), '0);
            tick();
        end
        run_op("enc128_after_rst", 0, 10, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
